// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the imem read port (addr/en/wr/data), the redirect input and the IF/ID handshake with status (if_*, halted, err)
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;
  logic        err;
  modport master (
    output imem_addr, imem_en, imem_wr, if_valid, if_instr, if_pc, if_pc_plus2, halted, err,
    input  imem_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_addr, imem_en, imem_wr, if_valid, if_instr, if_pc, if_pc_plus2, halted, err,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC + IF/ID register with redirect/flush, decode back-pressure and HALT detection; ports clk, rst (async active-low), f (fetch_stage_if.master)
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master f
);
  typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_t;
  state_t      state, state_nx;
  logic [15:0] pc;
  logic        redir, load, is_halt, halt_ack;
  assign redir    = f.redirect_valid;
  assign load     = state == RUN && (!f.if_valid || f.id_ready) && !redir;
  assign is_halt  = f.imem_data[15:11] == HALT_OPCODE;
  assign halt_ack = state == HALT_WAIT && f.id_ready;
  always_comb begin
    state_nx = state;
    state_nx = redir ? RUN : load ? (is_halt ? HALT_WAIT : RUN) : halt_ack ? HALTED : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc            <= RESET_PC;
      f.if_valid    <= 1'b0;
      f.if_instr    <= '0;
      f.if_pc       <= '0;
      f.if_pc_plus2 <= '0;
      f.err         <= 1'b0;
    end else begin
      if (redir) begin
        pc         <= {f.redirect_pc[15:1], 1'b0};
        f.if_valid <= 1'b0;
      end else if (load) begin
        f.if_instr    <= f.imem_data;
        f.if_pc       <= pc;
        f.if_pc_plus2 <= pc + 16'd2;
        f.if_valid    <= 1'b1;
        pc            <= is_halt ? pc : pc + 16'd2;
      end else if (halt_ack) begin
        f.if_valid <= 1'b0;
      end
      if (redir && f.redirect_pc[0]) f.err <= 1'b1;
    end
  assign f.imem_addr = pc;
  assign f.imem_en   = state == RUN && rst;
  assign f.imem_wr   = 1'b0;
  assign f.halted    = state == HALTED;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch_stage bench against a behavioural model, with directed literal checks
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fetch_stage_if f();
  fetch_stage dut (.clk(clk), .rst(rst), .f(f));
  logic [15:0] mem [0:32767];
  assign f.imem_data = mem[f.imem_addr[15:1]];
  logic [15:0] m_pc, m_instr, m_ipc, m_w;
  logic        m_v, m_hw, m_hd, m_err;
  assign m_w = mem[m_pc[15:1]];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_pc <= 16'h0000; m_v <= 1'b0; m_instr <= '0; m_ipc <= '0;
      m_hw <= 1'b0; m_hd <= 1'b0; m_err <= 1'b0;
    end else if (f.redirect_valid) begin
      m_err <= m_err | f.redirect_pc[0];
      m_pc  <= f.redirect_pc & 16'hFFFE;
      m_v   <= 1'b0; m_hw <= 1'b0; m_hd <= 1'b0;
    end else if (!m_hw && !m_hd && (!m_v || f.id_ready)) begin
      m_instr <= m_w; m_ipc <= m_pc; m_v <= 1'b1;
      if (m_w[15:11] == 5'd0) m_hw <= 1'b1;
      else m_pc <= m_pc + 16'd2;
    end else if (m_hw && f.id_ready) begin
      m_v <= 1'b0; m_hw <= 1'b0; m_hd <= 1'b1;
    end
  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (check_en) begin
      chk("if_valid", {15'd0, f.if_valid}, {15'd0, m_v});
      chk("imem_addr", f.imem_addr, m_pc);
      chk("imem_en", {15'd0, f.imem_en}, {15'd0, rst && !m_hw && !m_hd});
      chk("imem_wr", {15'd0, f.imem_wr}, 16'd0);
      chk("halted", {15'd0, f.halted}, {15'd0, m_hd});
      chk("err", {15'd0, f.err}, {15'd0, m_err});
      if (m_v) begin
        chk("if_instr", f.if_instr, m_instr);
        chk("if_pc", f.if_pc, m_ipc);
        chk("if_pc_plus2", f.if_pc_plus2, m_ipc + 16'd2);
      end
    end
  task automatic cyc(input logic rv, input logic [15:0] rp, input logic rd);
    #1;
    f.redirect_valid = rv;
    f.redirect_pc = rp;
    f.id_ready = rd;
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] w, rp;
    logic rv, rd;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'd0) w[15:11] = 5'd1;
      mem[i] = w;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h0000;
    mem[16'h0008] = 16'h5A5A; mem[16'h0009] = 16'h6789; mem[16'h0020] = 16'h4567;
    mem[16'h7FFF] = 16'hABCD;
    mem[16'h0030] = 16'h0000; mem[16'h0050] = 16'h07FF; mem[16'h0070] = 16'h0000;
    f.redirect_valid = 1'b0; f.redirect_pc = '0; f.id_ready = 1'b0;
    @(negedge clk);
    chk("rst if_valid", {15'd0, f.if_valid}, 16'd0);
    chk("rst imem_en", {15'd0, f.imem_en}, 16'd0);
    chk("rst if_instr", f.if_instr, 16'd0);
    chk("rst if_pc_plus2", f.if_pc_plus2, 16'd0);
    #1 rst = 1'b1;
    check_en = 1'b1;
    cyc(0, 0, 1);
    chk("seq0 instr", f.if_instr, 16'h1111); chk("seq0 pc", f.if_pc, 16'h0000); chk("seq0 pc2", f.if_pc_plus2, 16'h0002);
    cyc(0, 0, 1);
    chk("seq1 instr", f.if_instr, 16'h2222); chk("seq1 pc", f.if_pc, 16'h0002); chk("seq1 pc2", f.if_pc_plus2, 16'h0004);
    repeat (3) begin
      cyc(0, 0, 0);
      chk("stall instr", f.if_instr, 16'h2222); chk("stall pc", f.if_pc, 16'h0002); chk("stall addr", f.imem_addr, 16'h0004);
    end
    cyc(0, 0, 1);
    chk("seq2 instr", f.if_instr, 16'h3333); chk("seq2 pc", f.if_pc, 16'h0004); chk("seq2 pc2", f.if_pc_plus2, 16'h0006);
    cyc(1, 16'h0040, 1);
    chk("redir valid", {15'd0, f.if_valid}, 16'd0); chk("redir addr", f.imem_addr, 16'h0040);
    cyc(0, 0, 1);
    chk("redir pc", f.if_pc, 16'h0040); chk("redir instr", f.if_instr, 16'h4567);
    cyc(1, 16'h0006, 1);
    repeat (2) begin
      cyc(0, 0, 0);
      chk("halt instr", f.if_instr, 16'h0000); chk("halt pc", f.if_pc, 16'h0006);
      chk("halt en", {15'd0, f.imem_en}, 16'd0); chk("halt valid", {15'd0, f.if_valid}, 16'd1);
      chk("halt waiting", {15'd0, f.halted}, 16'd0);
    end
    repeat (2) begin
      cyc(0, 0, 1);
      chk("halted", {15'd0, f.halted}, 16'd1); chk("halted valid", {15'd0, f.if_valid}, 16'd0);
    end
    cyc(1, 16'h0010, 1);
    chk("resume halted", {15'd0, f.halted}, 16'd0); chk("resume addr", f.imem_addr, 16'h0010);
    cyc(0, 0, 1);
    chk("resume pc", f.if_pc, 16'h0010); chk("resume instr", f.if_instr, 16'h5A5A);
    cyc(1, 16'h0013, 1);
    chk("misalign err", {15'd0, f.err}, 16'd1); chk("misalign addr", f.imem_addr, 16'h0012);
    cyc(0, 0, 1);
    chk("misalign pc", f.if_pc, 16'h0012); chk("misalign instr", f.if_instr, 16'h6789);
    cyc(1, 16'hFFFE, 1);
    cyc(0, 0, 1);
    chk("wrap pc", f.if_pc, 16'hFFFE); chk("wrap pc2", f.if_pc_plus2, 16'h0000); chk("wrap instr", f.if_instr, 16'hABCD);
    cyc(0, 0, 1);
    chk("wrap next pc", f.if_pc, 16'h0000); chk("wrap next instr", f.if_instr, 16'h1111);
    chk("err sticky", {15'd0, f.err}, 16'd1);
    repeat (3000) begin
      rv = $urandom_range(0, 9) == 0;
      rp = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      rd = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      cyc(rv, rp, rd);
    end
    cyc(1, 16'h0013, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("pre-reset valid", {15'd0, f.if_valid}, 16'd1);
    chk("pre-reset err", {15'd0, f.err}, 16'd1);
    #3 rst = 1'b0;
    #1;
    chk("async valid", {15'd0, f.if_valid}, 16'd0);
    chk("async instr", f.if_instr, 16'd0);
    chk("async pc", f.if_pc, 16'd0);
    chk("async pc2", f.if_pc_plus2, 16'd0);
    chk("async err", {15'd0, f.err}, 16'd0);
    chk("async halted", {15'd0, f.halted}, 16'd0);
    chk("async en", {15'd0, f.imem_en}, 16'd0);
    chk("async addr", f.imem_addr, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the byte-addressed, 16-bit-wide instruction memory (`memory_instr`). It owns the program counter, drives the memory's combinational read port, and captures each returned instruction into an IF/ID pipeline register. Toward decode it offers a valid/ready handshake. It also handles branch redirects with flush, decode back-pressure, and HALT detection.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `HALT_OPCODE`, 5'b00000, value of instr[15:11] that marks a HALT instruction
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `imem_addr`  out  16  byte address to instruction memory; equals PC, always even
- `imem_en`  out  1  read enable to instruction memory
- `imem_wr`  out  1  tied 0; the stage never writes instruction memory
- `imem_data`  in  16  combinational read data from instruction memory
- `redirect_valid`  in  1  branch/jump resolved taken this cycle
- `redirect_pc`  in  16  target address, valid with `redirect_valid`
- `id_ready`  in  1  decode accepts IF/ID contents this cycle
- `if_valid`  out  1  IF/ID register holds a live instruction
- `if_instr`  out  16  captured instruction
- `if_pc`  out  16  address of `if_instr`
- `if_pc_plus2`  out  16  `if_pc` + 2, mod 2^16
- `halted`  out  1  HALT has been handed to decode and fetch has stopped
- `err`  out  1  sticky: a misaligned redirect target was received

## Operation
- The stage has three states:
  - **RUN**: fetching.
  - **HALT_WAIT**: a HALT instruction is in IF/ID, waiting for decode.
  - **HALTED**: fetch has stopped.
- `imem_addr` = PC, `imem_wr` = 0.
- `imem_en` = 1 only when the state is RUN and `rst` = 1.
- A load occurs when the state is RUN and (`!if_valid` or `id_ready`). On a load:
  - IF/ID <= {`imem_data`, PC, PC+2}.
  - `if_valid` <= 1.
  - PC <= PC+2.
- If the loaded instruction has `imem_data[15:11]` == `HALT_OPCODE`:
  - The HALT is still loaded into IF/ID.
  - PC holds at the HALT's address.
  - Next state is HALT_WAIT.
- Stall: when `if_valid` = 1 and `id_ready` = 0, PC and IF/ID hold unchanged.
- HALT_WAIT: when `id_ready` = 1, `if_valid` <= 0 and the next state is HALTED.
- HALTED: `halted` = 1, `if_valid` = 0, and nothing is fetched.
- Redirect (`redirect_valid` = 1) has highest priority in every state:
  - PC <= {`redirect_pc[15:1]`, 1'b0}.
  - `if_valid` <= 0 (flush).
  - Next state is RUN; `halted` drops the next cycle.
  - No load occurs that cycle.
- If `redirect_pc[0]` = 1 during a redirect, `err` <= 1. `err` clears only on reset.
- PC arithmetic is 16-bit unsigned: 16'hFFFE + 2 wraps to 16'h0000. `if_pc_plus2` wraps the same way.

## Timing
- Reset (asynchronous, immediate):
  - PC = `RESET_PC`, state RUN.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_pc_plus2` = 0.
  - `halted` = 0, `err` = 0.
  - `imem_en` = 0 while `rst` = 0.
- The first fetch happens in the first cycle after `rst` rises. `if_valid` = 1 after the first rising edge with `rst` = 1.
- Fetch latency: memory read is zero-delay, so an instruction appears on the `if_*` outputs one edge after PC presents its address.
- Throughput: one instruction per cycle while `id_ready` = 1.
- Handshake: a transfer occurs on an edge where `if_valid` and `id_ready` are both 1. Outputs stay stable while `if_valid` = 1 and `id_ready` = 0.
- Redirect and `id_ready` in the same cycle: redirect wins, and the IF/ID instruction is discarded even though `id_ready` = 1.
- Redirect during HALT_WAIT: the HALT is discarded, `halted` never asserts, and fetch resumes at the target next cycle.
- Reset mid-stall or mid-halt returns all state to reset values immediately.
- `halted` asserts on the edge the HALT is accepted by decode.

## Test plan
- Reset with `RESET_PC`=0 and memory words 0x1111, 0x2222, 0x3333 at byte addresses 0, 2, 4; `id_ready`=1:
  - Consecutive cycles give `if_instr` 0x1111/0x2222/0x3333.
  - `if_pc` reads 0/2/4 and `if_pc_plus2` reads 2/4/6.
- Stall: drop `id_ready` for 3 cycles while 0x2222 is in IF/ID:
  - Outputs hold 0x2222, pc=2.
  - `imem_addr` holds 4.
  - Resuming yields 0x3333 with no duplicate or skipped instruction.
- Redirect with `redirect_pc`=0x0040 while `if_valid`=1 and `id_ready`=1:
  - Next cycle `if_valid`=0 and `imem_addr`=0x0040.
  - The following cycle `if_pc`=0x0040.
- HALT (0x0000) at address 6, with `id_ready` held 0 for 2 cycles:
  - HALT stays in IF/ID and `imem_en`=0.
  - On accept, `halted`=1 and `if_valid`=0 thereafter.
  - A redirect to 0x0010 then resumes fetch.
- Misaligned redirect with `redirect_pc`=0x0013:
  - Fetch proceeds from 0x0012.
  - `err`=1, persisting until `rst`=0.
- Wrap-around: redirect to 0xFFFE.
  - The next two fetches come from 0xFFFE and 0x0000.
  - `if_pc_plus2` reads 0x0000 for the 0xFFFE instruction.
- Async reset asserted mid-stall clears all outputs without waiting for a clock edge.
